// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, IF/ID register, stall/branch-squash handling and
// optional halt on HALT_WORD (built only when FETCH_HALT_EN is defined).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fetch_error,
    output logic [31:0] fetch_count
);
    localparam logic [31:0] MASK = 32'(MEM_BYTES - 1);
    logic [31:0] pc, pc_plus4;
    logic active, do_halt;
    assign pc_plus4 = (pc + 32'd4) & MASK;
    assign imem_addr = pc;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
    typedef enum logic {FETCH, HALTED} state_t;
    state_t state, state_next;
    always_ff @(posedge clk)
        state <= reset ? FETCH : state_next;
    always_comb begin
        state_next = state;
        if (do_halt) state_next = HALTED;
    end
    assign active = state == FETCH;
    assign halted = state == HALTED;
`else
    localparam bit HALT_EN = 1'b0;
    assign active = 1'b1;
    assign halted = 1'b0;
`endif
    assign do_halt = HALT_EN && active && !branch_taken && !stall && imem_instr == HALT_WORD;
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC & MASK;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
            fetch_error   <= 1'b0;
            fetch_count   <= '0;
        end else if (active) begin
            if (branch_taken) begin
                // squash the wrong-path fetch; branch beats stall
                pc         <= {branch_target[31:2], 2'b00} & MASK;
                ifid_instr <= '0;
                ifid_valid <= 1'b0;
                if (|branch_target[1:0]) fetch_error <= 1'b1;
            end else if (!stall) begin
                if (do_halt) begin
                    ifid_instr <= '0;
                    ifid_valid <= 1'b0;
                end else begin
                    ifid_instr    <= imem_instr;
                    ifid_pc_plus4 <= pc_plus4;
                    ifid_valid    <= 1'b1;
                    pc            <= pc_plus4;
                    fetch_count   <= fetch_count + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with hand-computed expectations;
// halt checks adapt to whether FETCH_HALT_EN is defined.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target, imem_instr, imem_addr;
    logic [31:0] ifid_instr, ifid_pc_plus4, fetch_count;
    logic        ifid_valid, halted, fetch_error;
    logic [31:0] mem [256];
    int errors = 0;
    int checks = 0;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_error(fetch_error), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0]   = 32'h0045_7820;
        mem[1]   = 32'h202D_0030;
        mem[8]   = 32'hFFFF_FFFF;
        mem[255] = 32'hABCD_0001;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc4", ifid_pc_plus4, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_err", {31'b0, fetch_error}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        step();
        chk("f1_addr", imem_addr, 32'h4);
        chk("f1_instr", ifid_instr, 32'h0045_7820);
        chk("f1_pc4", ifid_pc_plus4, 32'h4);
        chk("f1_valid", {31'b0, ifid_valid}, 32'h1);
        step();
        chk("f2_addr", imem_addr, 32'h8);
        chk("f2_instr", ifid_instr, 32'h202D_0030);
        chk("f2_pc4", ifid_pc_plus4, 32'h8);
        chk("f2_count", fetch_count, 32'h2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_instr", ifid_instr, 32'h202D_0030);
            chk("stall_count", fetch_count, 32'h2);
        end
        stall = 1'b0;
        step();
        chk("resume_addr", imem_addr, 32'hC);
        chk("resume_instr", ifid_instr, 32'h1000_0002);
        chk("resume_pc4", ifid_pc_plus4, 32'hC);
        chk("resume_count", fetch_count, 32'h3);

        branch_taken = 1'b1; branch_target = 32'h20; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        chk("br_addr", imem_addr, 32'h20);
        chk("br_valid", {31'b0, ifid_valid}, 32'h0);
        chk("br_instr", ifid_instr, 32'h0);
        chk("br_count", fetch_count, 32'h3);

        step();
`ifdef FETCH_HALT_EN
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_valid", {31'b0, ifid_valid}, 32'h0);
        chk("halt_addr", imem_addr, 32'h20);
        chk("halt_count", fetch_count, 32'h3);
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        chk("halt_br_addr", imem_addr, 32'h20);
        chk("halt_br_halted", {31'b0, halted}, 32'h1);
`else
        chk("nohalt_instr", ifid_instr, 32'hFFFF_FFFF);
        chk("nohalt_valid", {31'b0, ifid_valid}, 32'h1);
        chk("nohalt_halted", {31'b0, halted}, 32'h0);
        chk("nohalt_addr", imem_addr, 32'h24);
        chk("nohalt_count", fetch_count, 32'h4);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_halted", {31'b0, halted}, 32'h0);

        branch_taken = 1'b1; branch_target = 32'h16;
        step();
        branch_taken = 1'b0;
        chk("mis_addr", imem_addr, 32'h14);
        chk("mis_err", {31'b0, fetch_error}, 32'h1);
        chk("mis_count", fetch_count, 32'h0);
        step();
        chk("mis_f1_instr", ifid_instr, 32'h1000_0005);
        chk("mis_f1_err", {31'b0, fetch_error}, 32'h1);
        step();
        chk("mis_f2_count", fetch_count, 32'h2);
        chk("mis_f2_err", {31'b0, fetch_error}, 32'h1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst3_err", {31'b0, fetch_error}, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h3FC;
        step();
        branch_taken = 1'b0;
        chk("wrap_pre_addr", imem_addr, 32'h3FC);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", ifid_pc_plus4, 32'h0);
        chk("wrap_instr", ifid_instr, 32'hABCD_0001);
        chk("wrap_err", {31'b0, fetch_error}, 32'h0);
        chk("wrap_count", fetch_count, 32'h1);

        branch_taken = 1'b1; branch_target = 32'h404;
        step();
        branch_taken = 1'b0;
        chk("bigtgt_addr", imem_addr, 32'h4);
        chk("bigtgt_err", {31'b0, fetch_error}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
